// File: rtl/bsram_be.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : bsram_be                                                          |
// | Brief  : 1R/1W synchronous block RAM with byte enables, read-during-write  |
// |          selection, optional output register and a self-clearing engine.   |
// | Rev    : 1.0  initial release                                              |
// +----------------------------------------------------------------------------+
module bsram_be #(
    parameter int unsigned           DATA_WIDTH = 16,
    parameter int unsigned           BYTE_WIDTH = 8,
    parameter int unsigned           ADDR_WIDTH = 13,
    parameter int unsigned           SIZE       = 8192,
    parameter bit                    RDW_MODE   = 1'b0,
    parameter bit                    OUT_REG    = 1'b0,
    parameter logic [DATA_WIDTH-1:0] INIT_VALUE = '0,
    localparam int unsigned          NB         = DATA_WIDTH / BYTE_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  re,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_valid,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [NB-1:0]         wr_be,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  clr_req,
    output logic                  busy
);

    localparam int unsigned         c_iw       = (SIZE > 1) ? $clog2(SIZE) : 1;
    localparam logic [ADDR_WIDTH:0] c_size     = (ADDR_WIDTH+1)'(SIZE);
    localparam logic [ADDR_WIDTH:0] c_last     = c_size - 1'b1;
    localparam logic [0:0]          c_st_idle  = 1'b0;
    localparam logic [0:0]          c_st_clear = 1'b1;

    logic [DATA_WIDTH-1:0] r_mem [0:SIZE-1];

    logic [0:0]            r_state;
    logic [0:0]            w_state_nxt;
    logic [ADDR_WIDTH:0]   r_clr_cnt;
    logic [ADDR_WIDTH:0]   w_clr_cnt_nxt;
    logic                  w_clr_wr;
    logic                  r_busy;
    logic                  r_rd_valid;
    logic [DATA_WIDTH-1:0] r_rd_data;

    logic                  w_rd_accept;
    logic                  w_wr_accept;
    logic                  w_rd_in_range;
    logic                  w_wr_in_range;
    logic [c_iw-1:0]       w_rd_idx;
    logic [c_iw-1:0]       w_wr_idx;
    logic [c_iw-1:0]       w_clr_idx;
    logic [DATA_WIDTH-1:0] w_rd_old;
    logic [DATA_WIDTH-1:0] w_rd_word;

    assign w_rd_accept   = re & ~r_busy;
    assign w_wr_accept   = we & ~r_busy;
    assign w_rd_in_range = ({1'b0, rd_addr} < c_size);
    assign w_wr_in_range = ({1'b0, wr_addr} < c_size);
    assign w_rd_idx      = rd_addr[c_iw-1:0];
    assign w_wr_idx      = wr_addr[c_iw-1:0];
    assign w_clr_idx     = r_clr_cnt[c_iw-1:0];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= c_st_clear;
            r_clr_cnt <= '0;
            r_busy    <= 1'b1;
        end else begin
            r_state   <= w_state_nxt;
            r_clr_cnt <= w_clr_cnt_nxt;
            r_busy    <= (w_state_nxt == c_st_clear);
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_clr_cnt_nxt = r_clr_cnt;
        w_clr_wr      = 1'b0;
        case (r_state)
            c_st_clear: begin
                w_clr_wr      = 1'b1;
                w_clr_cnt_nxt = r_clr_cnt + 1'b1;
                if (r_clr_cnt == c_last) begin
                    w_state_nxt = c_st_idle;
                end
            end
            default: begin
                if (clr_req) begin
                    w_state_nxt   = c_st_clear;
                    w_clr_cnt_nxt = '0;
                end
            end
        endcase
    end

    // Memory array is never touched while reset is held, so contents survive a reset.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            if (w_clr_wr) begin
                r_mem[w_clr_idx] <= INIT_VALUE;
            end else if (w_wr_accept && w_wr_in_range) begin
                for (int i = 0; i < NB; i++) begin
                    if (wr_be[i]) begin
                        r_mem[w_wr_idx][i*BYTE_WIDTH +: BYTE_WIDTH] <= wr_data[i*BYTE_WIDTH +: BYTE_WIDTH];
                    end
                end
            end
        end
    end

    assign w_rd_old = w_rd_in_range ? r_mem[w_rd_idx] : '0;

    // New-data mode forwards the enabled write lanes onto a colliding read.
    always_comb begin
        w_rd_word = w_rd_old;
        if (RDW_MODE && w_wr_accept && w_rd_in_range && (rd_addr == wr_addr)) begin
            for (int i = 0; i < NB; i++) begin
                if (wr_be[i]) begin
                    w_rd_word[i*BYTE_WIDTH +: BYTE_WIDTH] = wr_data[i*BYTE_WIDTH +: BYTE_WIDTH];
                end
            end
        end
    end

    generate
        if (OUT_REG) begin : g_out_reg
            logic                  r_s1_valid;
            logic [DATA_WIDTH-1:0] r_s1_data;

            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    r_s1_valid <= 1'b0;
                    r_s1_data  <= '0;
                    r_rd_valid <= 1'b0;
                    r_rd_data  <= '0;
                end else begin
                    r_s1_valid <= w_rd_accept;
                    if (w_rd_accept) begin
                        r_s1_data <= w_rd_word;
                    end
                    r_rd_valid <= r_s1_valid;
                    if (r_s1_valid) begin
                        r_rd_data <= r_s1_data;
                    end
                end
            end
        end else begin : g_no_out_reg
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    r_rd_valid <= 1'b0;
                    r_rd_data  <= '0;
                end else begin
                    r_rd_valid <= w_rd_accept;
                    if (w_rd_accept) begin
                        r_rd_data <= w_rd_word;
                    end
                end
            end
        end
    endgenerate

    assign rd_data  = r_rd_data;
    assign rd_valid = r_rd_valid;
    assign busy     = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_bsram_be.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : tb_bsram_be                                                       |
// | Brief  : Directed bench for bsram_be, two configurations driven in parallel|
// | Rev    : 1.0  initial release                                              |
// +----------------------------------------------------------------------------+
module tb_bsram_be;

    localparam int          c_size = 256;
    localparam int          c_aw   = 9;
    localparam logic [15:0] c_init = 16'hA5C3;

    logic           clk = 1'b0;
    logic           rst_n;
    logic           re;
    logic [c_aw-1:0] rd_addr;
    logic           we;
    logic [c_aw-1:0] wr_addr;
    logic [1:0]     wr_be;
    logic [15:0]    wr_data;
    logic           clr_req;

    logic [15:0]    rd_data0, rd_data1;
    logic           rd_valid0, rd_valid1, busy0, busy1;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    // dut0: old-data, latency 1; dut1: new-data, latency 2
    bsram_be #(.DATA_WIDTH(16), .BYTE_WIDTH(8), .ADDR_WIDTH(c_aw), .SIZE(c_size),
               .RDW_MODE(1'b0), .OUT_REG(1'b0), .INIT_VALUE(c_init)) dut0 (
        .clk(clk), .rst_n(rst_n), .re(re), .rd_addr(rd_addr), .rd_data(rd_data0),
        .rd_valid(rd_valid0), .we(we), .wr_addr(wr_addr), .wr_be(wr_be),
        .wr_data(wr_data), .clr_req(clr_req), .busy(busy0));

    bsram_be #(.DATA_WIDTH(16), .BYTE_WIDTH(8), .ADDR_WIDTH(c_aw), .SIZE(c_size),
               .RDW_MODE(1'b1), .OUT_REG(1'b1), .INIT_VALUE(c_init)) dut1 (
        .clk(clk), .rst_n(rst_n), .re(re), .rd_addr(rd_addr), .rd_data(rd_data1),
        .rd_valid(rd_valid1), .we(we), .wr_addr(wr_addr), .wr_be(wr_be),
        .wr_data(wr_data), .clr_req(clr_req), .busy(busy1));

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Behavioural model: memory image, remaining clear cycles, expected outputs
    logic [15:0] m_mem [c_size];
    int          m_clear_left = 0;
    bit          m_on = 1'b0;
    logic        m_acc;
    logic [15:0] m_old, m_new;
    logic        e0v, p1v, e1v;
    logic [15:0] e0d, p1d, e1d;

    always @(posedge clk) begin
        if (!rst_n) begin
            m_on = 1'b1;
            m_clear_left = c_size;
            e0v = 1'b0; e0d = '0; p1v = 1'b0; p1d = '0; e1v = 1'b0; e1d = '0;
        end else if (m_on) begin
            m_acc = re && (m_clear_left == 0);
            m_old = (int'(rd_addr) < c_size) ? m_mem[rd_addr] : 16'h0000;
            m_new = m_old;
            if (m_acc && we && rd_addr == wr_addr && int'(rd_addr) < c_size)
                for (int i = 0; i < 2; i++)
                    if (wr_be[i]) m_new[i*8 +: 8] = wr_data[i*8 +: 8];
            e1v = p1v;
            if (p1v) e1d = p1d;
            p1v = m_acc;
            if (m_acc) p1d = m_new;
            e0v = m_acc;
            if (m_acc) e0d = m_old;
            if (m_clear_left == 0 && we && int'(wr_addr) < c_size)
                for (int i = 0; i < 2; i++)
                    if (wr_be[i]) m_mem[wr_addr][i*8 +: 8] = wr_data[i*8 +: 8];
            if (m_clear_left > 0) begin
                m_clear_left--;
                if (m_clear_left == 0)
                    for (int a = 0; a < c_size; a++) m_mem[a] = c_init;
            end else if (clr_req) begin
                m_clear_left = c_size;
            end
        end
    end

    always @(negedge clk) begin
        if (m_on) begin
            chk("m_busy0", {31'b0, busy0}, {31'b0, m_clear_left > 0});
            chk("m_busy1", {31'b0, busy1}, {31'b0, m_clear_left > 0});
            chk("m_valid0", {31'b0, rd_valid0}, {31'b0, e0v});
            chk("m_valid1", {31'b0, rd_valid1}, {31'b0, e1v});
            chk("m_data0", {16'b0, rd_data0}, {16'b0, e0d});
            chk("m_data1", {16'b0, rd_data1}, {16'b0, e1d});
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic wr(input logic [c_aw-1:0] a, input logic [15:0] d, input logic [1:0] be);
        we = 1'b1; wr_addr = a; wr_data = d; wr_be = be;
        tick();
        we = 1'b0; wr_be = 2'b00;
    endtask

    task automatic read_chk(input string nm, input logic [c_aw-1:0] a,
                            input logic [15:0] e0, input logic [15:0] e1);
        re = 1'b1; rd_addr = a;
        tick();
        re = 1'b0;
        chk({nm, "_v0"}, {31'b0, rd_valid0}, 32'd1);
        chk({nm, "_d0"}, {16'b0, rd_data0}, {16'b0, e0});
        tick();
        chk({nm, "_v1"}, {31'b0, rd_valid1}, 32'd1);
        chk({nm, "_d1"}, {16'b0, rd_data1}, {16'b0, e1});
    endtask

    task automatic count_busy(input string nm);
        int n;
        n = 0;
        while (busy0 && n < c_size + 20) begin
            tick();
            n++;
        end
        chk(nm, n, c_size);
    endtask

    initial begin
        int n;
        rst_n = 1'b0; re = 1'b0; rd_addr = '0; we = 1'b0; wr_addr = '0;
        wr_be = 2'b00; wr_data = '0; clr_req = 1'b0;

        // T1: reset state and initial clear pass
        tick(); tick();
        chk("t1_rst_valid0", {31'b0, rd_valid0}, 32'd0);
        chk("t1_rst_data1", {16'b0, rd_data1}, 32'd0);
        chk("t1_rst_busy1", {31'b0, busy1}, 32'd1);
        rst_n = 1'b1;
        count_busy("t1_busy_len");
        read_chk("t1_a0", 9'd0, c_init, c_init);
        read_chk("t1_amid", 9'd128, c_init, c_init);
        read_chk("t1_alast", 9'd255, c_init, c_init);

        // T2: byte enables and empty-enable write
        wr(9'd5, 16'hABCD, 2'b11);
        wr(9'd5, 16'h1234, 2'b01);
        read_chk("t2_merge", 9'd5, 16'hAB34, 16'hAB34);
        wr(9'd5, 16'h0000, 2'b00);
        read_chk("t2_be0", 9'd5, 16'hAB34, 16'hAB34);

        // T3: read-during-write on the same address
        wr(9'd7, 16'h1111, 2'b11);
        re = 1'b1; rd_addr = 9'd7; we = 1'b1; wr_addr = 9'd7; wr_data = 16'h2222; wr_be = 2'b11;
        tick();
        re = 1'b0; we = 1'b0; wr_be = 2'b00;
        chk("t3_rdw_old", {16'b0, rd_data0}, 32'h1111);
        tick();
        chk("t3_rdw_new", {16'b0, rd_data1}, 32'h2222);
        re = 1'b1; rd_addr = 9'd7; we = 1'b1; wr_addr = 9'd7; wr_data = 16'h3344; wr_be = 2'b10;
        tick();
        re = 1'b0; we = 1'b0; wr_be = 2'b00;
        chk("t3_rdw_old_part", {16'b0, rd_data0}, 32'h2222);
        tick();
        chk("t3_rdw_new_part", {16'b0, rd_data1}, 32'h3322);
        read_chk("t3_after", 9'd7, 16'h3322, 16'h3322);

        // T4: clear on request, accesses dropped while busy
        for (int i = 0; i < 16; i++) wr(c_aw'(i), 16'h0101 * 16'(i + 1), 2'b11);
        clr_req = 1'b1;
        tick();
        clr_req = 1'b0;
        n = 0;
        while (busy0 && n < c_size + 20) begin
            if (n < 5) begin
                we = 1'b1; wr_addr = 9'd3; wr_data = 16'hFFFF; wr_be = 2'b11;
                re = 1'b1; rd_addr = 9'd3;
            end else begin
                we = 1'b0; re = 1'b0; wr_be = 2'b00;
            end
            tick();
            if (n < 5) chk("t4_busy_novalid", {31'b0, rd_valid0}, 32'd0);
            n++;
        end
        chk("t4_busy_len", n, c_size);
        for (int i = 0; i < 16; i++) read_chk("t4_cleared", c_aw'(i), c_init, c_init);

        // T5: reset in the middle of a clear pass
        clr_req = 1'b1;
        tick();
        clr_req = 1'b0;
        repeat (100) tick();
        chk("t5_busy_mid", {31'b0, busy0}, 32'd1);
        rst_n = 1'b0;
        tick();
        chk("t5_busy_rst", {31'b0, busy1}, 32'd1);
        rst_n = 1'b1;
        count_busy("t5_busy_len");
        read_chk("t5_after", 9'd200, c_init, c_init);

        // T6: back-to-back reads, out-of-range accesses
        for (int i = 0; i < 32; i++) wr(c_aw'(i), 16'h1000 + 16'(i), 2'b11);
        for (int i = 0; i < 34; i++) begin
            if (i < 32) begin
                re = 1'b1; rd_addr = c_aw'(i);
            end else begin
                re = 1'b0;
            end
            tick();
            if (i < 32) chk("t6_stream_d0", {16'b0, rd_data0}, 32'h1000 + 32'(i));
            if (i >= 1 && i <= 32) begin
                chk("t6_stream_v1", {31'b0, rd_valid1}, 32'd1);
                chk("t6_stream_d1", {16'b0, rd_data1}, 32'h1000 + 32'(i - 1));
            end
        end
        read_chk("t6_oor_read", 9'd256, 16'h0000, 16'h0000);
        wr(9'd300, 16'hBEEF, 2'b11);
        read_chk("t6_oor_write", 9'd44, c_init, c_init);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
